// File: rtl/ysyx_23060236_btb.sv
// Direct-mapped branch target buffer between EXU (writes) and IFU (lookups).
// Lookups see flush-then-write state of the same edge and answer one cycle later.
module ysyx_23060236_btb #(
   parameter int IDX_W = 4,
   parameter int PC_W  = 25
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            btb_wvalid,
   input  logic [PC_W-1:0] btb_wpc,
   input  logic [31:0]     btb_wtarget,
   input  logic            btb_flush,
   input  logic            ifu_req_valid,
   input  logic [31:0]     ifu_pc,
   output logic            pred_valid,
   output logic            pred_hit,
   output logic [31:0]     pred_target
);

   localparam int DEPTH = 1 << IDX_W;
   localparam int TAG_W = PC_W - 2 - IDX_W;

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [TAG_W-1:0] tag_q    [DEPTH];
   logic [31:0]      target_q [DEPTH];

   logic [IDX_W-1:0] w_idx, r_idx;
   logic [TAG_W-1:0] w_tag, r_tag;
   logic [PC_W-1:0]  wpc_plus4;
   logic             w_fall, w_fill;

   logic             bypass;
   logic [TAG_W-1:0] eff_tag;
   logic [31:0]      eff_target;
   logic             lookup_hit;

   logic             pred_valid_q;
   logic             pred_hit_q, pred_hit_d;
   logic [31:0]      pred_target_q, pred_target_d;

   // Only the PC window [PC_W-1:2] participates; aliasing above it is accepted.
   logic unused_bits;
   assign unused_bits = ^{ifu_pc[31:PC_W], ifu_pc[1:0], btb_wpc[1:0]};

   assign w_idx     = btb_wpc[IDX_W+1:2];
   assign w_tag     = btb_wpc[PC_W-1:IDX_W+2];
   assign r_idx     = ifu_pc[IDX_W+1:2];
   assign r_tag     = ifu_pc[PC_W-1:IDX_W+2];
   assign wpc_plus4 = btb_wpc + PC_W'(4);

   // A target equal to pc+4 means the branch fell through: drop the entry.
   assign w_fall = (btb_wtarget[PC_W-1:0] == wpc_plus4);
   assign w_fill = btb_wvalid && !w_fall;

   // NOTE: every variable assigned in always_comb gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      valid_d = valid_q;
      if (btb_flush) begin
         valid_d = '0;
      end
      if (btb_wvalid) begin
         valid_d[w_idx] = !w_fall;
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments so all
   // registers sample the pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // NOTE: the tag and target arrays are deliberately not reset; an entry is
   // only ever trusted through valid_q, so their power-up contents are harmless.
   always_ff @(posedge clock) begin
      if (w_fill) begin
         tag_q[w_idx]    <= w_tag;
         target_q[w_idx] <= btb_wtarget;
      end
   end

   // Write-first bypass; valid_d already carries the flush-then-write ordering.
   always_comb begin
      bypass     = btb_wvalid && (w_idx == r_idx);
      eff_tag    = tag_q[r_idx];
      eff_target = target_q[r_idx];
      if (bypass) begin
         eff_tag    = w_tag;
         eff_target = btb_wtarget;
      end
      lookup_hit = valid_d[r_idx] && (eff_tag == r_tag);
   end

   always_comb begin
      pred_hit_d    = pred_hit_q;
      pred_target_d = pred_target_q;
      if (ifu_req_valid) begin
         pred_hit_d    = lookup_hit;
         pred_target_d = lookup_hit ? eff_target : 32'h0;
      end
   end

   // Reset also drops a request sampled just before it, so no stale pulse follows.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pred_valid_q  <= 1'b0;
         pred_hit_q    <= 1'b0;
         pred_target_q <= 32'h0;
      end else begin
         pred_valid_q  <= ifu_req_valid;
         pred_hit_q    <= pred_hit_d;
         pred_target_q <= pred_target_d;
      end
   end

   assign pred_valid  = pred_valid_q;
   assign pred_hit    = pred_hit_q;
   assign pred_target = pred_target_q;

endmodule

// File: tb/tb_ysyx_23060236_btb.sv
// Scoreboard bench for ysyx_23060236_btb: each lookup pushes its expected
// response, and a negedge monitor pops and compares on every pred_valid pulse.
module tb_ysyx_23060236_btb;

   localparam int IDX_W = 4;
   localparam int PC_W  = 25;

   typedef struct packed {
      logic        hit;
      logic [31:0] tgt;
   } exp_t;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            btb_wvalid = 1'b0;
   logic [PC_W-1:0] btb_wpc = '0;
   logic [31:0]     btb_wtarget = '0;
   logic            btb_flush = 1'b0;
   logic            ifu_req_valid = 1'b0;
   logic [31:0]     ifu_pc = '0;
   logic            pred_valid;
   logic            pred_hit;
   logic [31:0]     pred_target;

   int errors = 0;
   int checks = 0;

   exp_t  exp_q  [$];
   string name_q [$];

   ysyx_23060236_btb #(.IDX_W(IDX_W), .PC_W(PC_W)) dut (
      .clock         (clock),
      .reset         (reset),
      .btb_wvalid    (btb_wvalid),
      .btb_wpc       (btb_wpc),
      .btb_wtarget   (btb_wtarget),
      .btb_flush     (btb_flush),
      .ifu_req_valid (ifu_req_valid),
      .ifu_pc        (ifu_pc),
      .pred_valid    (pred_valid),
      .pred_hit      (pred_hit),
      .pred_target   (pred_target)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic lookup(input string name, input logic [31:0] pc,
                         input logic hit, input logic [31:0] tgt);
      exp_t e;
      e.hit = hit;
      e.tgt = tgt;
      ifu_req_valid = 1'b1;
      ifu_pc        = pc;
      exp_q.push_back(e);
      name_q.push_back(name);
   endtask

   task automatic write_btb(input logic [PC_W-1:0] pc, input logic [31:0] tgt);
      btb_wvalid  = 1'b1;
      btb_wpc     = pc;
      btb_wtarget = tgt;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      btb_wvalid    = 1'b0;
      btb_flush     = 1'b0;
      ifu_req_valid = 1'b0;
   endtask

   always @(negedge clock) begin : monitor
      exp_t  e;
      string n;
      if (pred_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("spurious_pred_valid", 32'(pred_valid), 32'h0);
         end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check({n, "_hit"}, 32'(pred_hit), 32'(e.hit));
            check({n, "_tgt"}, pred_target, e.tgt);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timed out");
   end

   initial begin
      repeat (2) @(posedge clock);
      #1;
      check("rst_valid", 32'(pred_valid), 32'h0);
      check("rst_hit", 32'(pred_hit), 32'h0);
      check("rst_target", pred_target, 32'h0);
      reset = 1'b0;
      step();

      // Cold lookup misses; idle cycle afterwards gives no pulse.
      lookup("t1_cold", 32'h8000_0010, 1'b0, 32'h0);
      step();
      step();
      check("t1_idle_valid", 32'(pred_valid), 32'h0);

      // Basic fill, hit, output hold, then tag mismatch on the same index.
      write_btb(25'h000_0040, 32'h8000_0020);
      step();
      lookup("t2_hit", 32'h8000_0040, 1'b1, 32'h8000_0020);
      step();
      step();
      check("t2_hold_valid", 32'(pred_valid), 32'h0);
      check("t2_hold_hit", 32'(pred_hit), 32'h1);
      check("t2_hold_tgt", pred_target, 32'h8000_0020);
      lookup("t2_tagmiss", 32'h8000_0080, 1'b0, 32'h0);
      step();

      // Fall-through resolution invalidates the entry.
      write_btb(25'h000_0040, 32'h8000_0044);
      step();
      lookup("t3_fall", 32'h8000_0040, 1'b0, 32'h0);
      step();

      // Same-cycle write/lookup bypass, then a back-to-back repeat from storage.
      write_btb(25'h000_004C, 32'h8000_1000);
      lookup("t4_bypass", 32'h8000_004C, 1'b1, 32'h8000_1000);
      step();
      lookup("t4_stored", 32'h8000_004C, 1'b1, 32'h8000_1000);
      step();
      // Bypassed fall-through write must miss in the same cycle.
      write_btb(25'h000_004C, 32'h8000_0050);
      lookup("t4_bypass_fall", 32'h8000_004C, 1'b0, 32'h0);
      step();

      // Fill every index, then flush together with one write.
      for (int i = 0; i < 16; i++) begin
         write_btb(PC_W'(i * 4), 32'h8000_3000 + 32'(i * 16));
         step();
      end
      lookup("t5_prefill", 32'h8000_0008, 1'b1, 32'h8000_3020);
      step();
      btb_flush = 1'b1;
      write_btb(25'h000_000C, 32'h8000_0200);
      lookup("t5_flush_same", 32'h8000_0004, 1'b0, 32'h0);
      step();
      for (int i = 0; i < 16; i++) begin
         if (i == 3) begin
            lookup($sformatf("t5_post_%0d", i), 32'h8000_0000 + 32'(i * 4), 1'b1, 32'h8000_0200);
         end else begin
            lookup($sformatf("t5_post_%0d", i), 32'h8000_0000 + 32'(i * 4), 1'b0, 32'h0);
         end
         step();
      end
      step();

      // Reset asserted asynchronously while a hitting lookup is pending.
      write_btb(25'h000_0050, 32'h8000_0500);
      step();
      lookup("t6_pre", 32'h8000_0050, 1'b1, 32'h8000_0500);
      step();
      step();
      check("t6_pre_hold_hit", 32'(pred_hit), 32'h1);
      ifu_req_valid = 1'b1;
      ifu_pc        = 32'h8000_0050;
      #2;
      reset = 1'b1;
      #1;
      check("t6_async_valid", 32'(pred_valid), 32'h0);
      check("t6_async_hit", 32'(pred_hit), 32'h0);
      check("t6_async_tgt", pred_target, 32'h0);
      ifu_req_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      step();
      check("t6_no_stale_pulse", 32'(pred_valid), 32'h0);
      lookup("t6_after_reset", 32'h8000_0050, 1'b0, 32'h0);
      step();
      step();
      step();

      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
